// File: rtl/gpu_text_pkg.sv
// Shared definitions for the text-mode GPU character path.
//   TEXT_COLS/TEXT_ROWS/TEXT_CELLS : default screen geometry
//   FILL_CHAR                      : code written by clears and backspace
//   ASCII_*                        : terminal control codes decoded by the writer
//   console_state_t                : writer FSM state encoding
package gpu_text_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 30;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [7:0] FILL_CHAR       = 8'h20;
  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] ASCII_FF        = 8'h0C;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_CLR_LINE = 2'd2,
    ST_CLR_ALL  = 2'd3
  } console_state_t;

endpackage

// File: rtl/text_fill_engine.sv
// Sequential fill of a run of char RAM cells.
//   clk, rst_n : clock, async active-low reset
//   start      : load base/len and begin writing next cycle
//   base       : first cell address of the run
//   len        : number of cells (1..4096)
//   address    : current cell address (registered)
//   v_w_en     : high for every cycle a cell is written
//   done       : high during the cycle the last cell is written
module text_fill_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] base,
  input  logic [12:0] len,
  output logic [11:0] address,
  output logic        v_w_en,
  output logic        done
);

  logic [11:0] addr_q, addr_d;
  logic [11:0] cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [12:0] len_m1;

  assign len_m1 = len - 13'd1;

  // cnt_q holds the number of cells still to write after the current one,
  // so the terminal count is a compare against zero.
  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      active_d = 1'b1;
      addr_d   = base;
      cnt_d    = len_m1[11:0];
    end else if (active_q) begin
      if (cnt_q == 12'd0) begin
        active_d = 1'b0;
      end else begin
        addr_d = addr_q + 12'd1;
        cnt_d  = cnt_q - 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign address = addr_q;
  assign v_w_en  = active_q;
  assign done    = active_q && (cnt_q == 12'd0);

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for the text-mode GPU char RAM.
// Decodes printable bytes and BS/LF/CR/FF, keeps the cursor, and performs
// line wrap, new-row blanking and full-screen clear.
//   clk, rst_n            : clock, async active-low reset
//   ch, ch_valid/ch_ready : byte input handshake (ready only in IDLE)
//   address, dout, v_w_en : char RAM write port
//   cursor_col/cursor_row : current cursor position
//   busy                  : high whenever not IDLE
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | waiting for a byte, ch_ready high
// ST_WRITE    | one cell write (printable char or BS blank)
// ST_CLR_LINE | blanking the COLS cells of the row the cursor moved to
// ST_CLR_ALL  | blanking the whole screen, cursor homes when done
module text_console_writer #(
  parameter int         COLS           = gpu_text_pkg::TEXT_COLS,
  parameter int         ROWS           = gpu_text_pkg::TEXT_ROWS,
  parameter logic [7:0] FILL_CHAR      = gpu_text_pkg::FILL_CHAR,
  parameter int         CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ch,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic [11:0] address,
  output logic [7:0]  dout,
  output logic        v_w_en,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  import gpu_text_pkg::*;

  localparam logic [6:0]     COL_LAST    = 7'(COLS - 1);
  localparam logic [4:0]     ROW_LAST    = 5'(ROWS - 1);
  localparam logic [11:0]    ROW_STRIDE  = 12'(COLS);
  localparam logic [12:0]    LINE_LEN    = 13'(COLS);
  localparam logic [12:0]    SCREEN_LEN  = 13'(COLS * ROWS);
  localparam console_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLR_ALL : ST_IDLE;
  localparam logic           KICK_RESET  = (CLEAR_ON_RESET != 0);

  console_state_t state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [11:0] row_base_q, row_base_d;
  logic [11:0] cur_addr_q, cur_addr_d;
  logic        wrap_q, wrap_d;
  logic        kick_q, kick_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_dout_q, wr_dout_d;
  logic        wr_en_q, wr_en_d;
  logic        ch_ready_q, ch_ready_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic [4:0]  next_row;
  logic [11:0] next_base;
  logic        fill_start;
  logic [11:0] fill_base;
  logic [12:0] fill_len;
  logic [11:0] fill_addr;
  logic        fill_en;
  logic        fill_done;

  assign accept = ch_valid && ch_ready_q;

  // No scrolling: the row after the last one is row 0 again.
  assign next_row  = (row_q == ROW_LAST) ? 5'd0  : row_q + 5'd1;
  assign next_base = (row_q == ROW_LAST) ? 12'd0 : row_base_q + ROW_STRIDE;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    cur_addr_d = cur_addr_q;
    wrap_d     = wrap_q;
    kick_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_dout_d  = wr_dout_q;
    wr_en_d    = 1'b0;
    fill_start = 1'b0;
    fill_base  = row_base_q;
    fill_len   = LINE_LEN;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (ch >= ASCII_PRINT_MIN) begin
            wr_addr_d = cur_addr_q;
            wr_dout_d = ch;
            wr_en_d   = 1'b1;
            state_d   = ST_WRITE;
            if (col_q == COL_LAST) begin
              col_d      = 7'd0;
              row_d      = next_row;
              row_base_d = next_base;
              cur_addr_d = next_base;
              wrap_d     = 1'b1;
            end else begin
              col_d      = col_q + 7'd1;
              cur_addr_d = cur_addr_q + 12'd1;
              wrap_d     = 1'b0;
            end
          end else begin
            case (ch)
              ASCII_LF: begin
                col_d      = 7'd0;
                row_d      = next_row;
                row_base_d = next_base;
                cur_addr_d = next_base;
                fill_start = 1'b1;
                fill_base  = next_base;
                fill_len   = LINE_LEN;
                state_d    = ST_CLR_LINE;
              end
              ASCII_CR: begin
                col_d      = 7'd0;
                cur_addr_d = row_base_q;
              end
              ASCII_BS: begin
                // Backspace never backs up into the previous row.
                if (col_q != 7'd0) begin
                  col_d      = col_q - 7'd1;
                  cur_addr_d = cur_addr_q - 12'd1;
                  wr_addr_d  = cur_addr_q - 12'd1;
                  wr_dout_d  = FILL_CHAR;
                  wr_en_d    = 1'b1;
                  wrap_d     = 1'b0;
                  state_d    = ST_WRITE;
                end
              end
              ASCII_FF: begin
                fill_start = 1'b1;
                fill_base  = 12'd0;
                fill_len   = SCREEN_LEN;
                state_d    = ST_CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      ST_WRITE: begin
        // The cursor already sits on the new row when a wrap happened.
        wrap_d = 1'b0;
        if (wrap_q) begin
          fill_start = 1'b1;
          fill_base  = row_base_q;
          fill_len   = LINE_LEN;
          state_d    = ST_CLR_LINE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLR_LINE: begin
        if (fill_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_CLR_ALL: begin
        // After reset the clear has not been started by a decoded FF.
        if (kick_q) begin
          fill_start = 1'b1;
          fill_base  = 12'd0;
          fill_len   = SCREEN_LEN;
        end else if (fill_done) begin
          col_d      = 7'd0;
          row_d      = 5'd0;
          row_base_d = 12'd0;
          cur_addr_d = 12'd0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ch_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      cur_addr_q <= '0;
      wrap_q     <= 1'b0;
      kick_q     <= KICK_RESET;
      wr_addr_q  <= '0;
      wr_dout_q  <= '0;
      wr_en_q    <= 1'b0;
      ch_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      wrap_q     <= wrap_d;
      kick_q     <= kick_d;
      wr_addr_q  <= wr_addr_d;
      wr_dout_q  <= wr_dout_d;
      wr_en_q    <= wr_en_d;
      ch_ready_q <= ch_ready_d;
      busy_q     <= busy_d;
    end
  end

  text_fill_engine u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (fill_start),
    .base    (fill_base),
    .len     (fill_len),
    .address (fill_addr),
    .v_w_en  (fill_en),
    .done    (fill_done)
  );

  // Single writes and fills never overlap, so the port is a plain
  // select between two register sets.
  assign address    = fill_en ? fill_addr : wr_addr_q;
  assign dout       = fill_en ? FILL_CHAR : wr_dout_q;
  assign v_w_en     = fill_en | wr_en_q;
  assign ch_ready   = ch_ready_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer (80x30, FILL 8'h20, clear on reset).
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [11:0] address;
  logic [7:0]  dout;
  logic        v_w_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch         (ch),
    .ch_valid   (ch_valid),
    .ch_ready   (ch_ready),
    .address    (address),
    .dout       (dout),
    .v_w_en     (v_w_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  int          busy_tot = 0;

  always @(negedge clk) begin
    if (v_w_en === 1'b1) begin
      wa.push_back(address);
      wd.push_back(dout);
    end
    if (busy === 1'b1) busy_tot++;
  end

  task automatic chk_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ch = b;
    ch_valid = 1'b1;
    while (ch_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk_val("send_timeout", n, 0);
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    ch = 8'h00;
  endtask

  task automatic wait_idle(output int cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ch_ready !== 1'b1 && n < 5000);
    if (ch_ready !== 1'b1) chk_val("idle_timeout", 0, 1);
    cycles = n;
    @(posedge clk);
    #1;
  endtask

  // Mismatches of the cnt logged writes from index base against a run
  // starting at addr0 with constant data.
  function automatic int fill_errs(input int base, input int addr0, input int cnt);
    int e;
    e = 0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i >= wa.size()) e++;
      else if (int'(wa[base+i]) != addr0 + i || wd[base+i] != 8'h20) e++;
    end
    return e;
  endfunction

  function automatic int first_addr(input int base);
    if (wa.size() > base) return int'(wa[base]);
    return -1;
  endfunction

  initial begin
    int cyc, wbase, bbase, e, hits;
    logic [7:0] c;

    // 1: reset values, then the power-on screen clear
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_val("rst_cursor_col", int'(cursor_col), 0);
    chk_val("rst_cursor_row", int'(cursor_row), 0);
    chk_val("rst_address", int'(address), 0);
    chk_val("rst_dout", int'(dout), 0);
    chk_val("rst_v_w_en", int'(v_w_en), 0);
    chk_val("rst_ch_ready", int'(ch_ready), 0);
    chk_val("rst_busy", int'(busy), 1);
    wbase = wa.size();
    rst_n = 1'b1;
    wait_idle(cyc);
    chk_val("por_clear_cycles", cyc, 2401);
    chk_val("por_clear_count", wa.size() - wbase, 2400);
    chk_val("por_clear_errs", fill_errs(wbase, 0, 2400), 0);
    chk_val("por_cursor_col", int'(cursor_col), 0);
    chk_val("por_cursor_row", int'(cursor_row), 0);

    // 2: "AB"
    wbase = wa.size();
    bbase = busy_tot;
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle(cyc);
    chk_val("ab_write_count", wa.size() - wbase, 2);
    chk_val("ab_addr0", first_addr(wbase), 0);
    chk_val("ab_data0", (wa.size() > wbase) ? int'(wd[wbase]) : -1, 8'h41);
    chk_val("ab_addr1", first_addr(wbase + 1), 1);
    chk_val("ab_data1", (wa.size() > wbase + 1) ? int'(wd[wbase+1]) : -1, 8'h42);
    chk_val("ab_busy_cycles", busy_tot - bbase, 2);
    chk_val("ab_cursor_col", int'(cursor_col), 2);

    // CR back to column 0, no write
    wbase = wa.size();
    send_byte(8'h0D);
    wait_idle(cyc);
    chk_val("cr_write_count", wa.size() - wbase, 0);
    chk_val("cr_cursor_col", int'(cursor_col), 0);
    chk_val("cr_cursor_row", int'(cursor_row), 0);

    // 3: a full row of chars wraps and blanks row 1
    wbase = wa.size();
    bbase = busy_tot;
    for (int i = 0; i < 80; i++) begin
      c = 8'h41 + 8'(i % 26);
      send_byte(c);
    end
    wait_idle(cyc);
    chk_val("row_write_count", wa.size() - wbase, 160);
    e = 0;
    for (int i = 0; i < 80; i++) begin
      c = 8'h41 + 8'(i % 26);
      if (wbase + i >= wa.size()) e++;
      else if (int'(wa[wbase+i]) != i || wd[wbase+i] != c) e++;
    end
    chk_val("row_char_errs", e, 0);
    chk_val("row_last_char_addr", first_addr(wbase + 79), 79);
    chk_val("row_wrap_fill_errs", fill_errs(wbase + 80, 80, 80), 0);
    chk_val("row_busy_cycles", busy_tot - bbase, 160);
    chk_val("row_cursor_row", int'(cursor_row), 1);
    chk_val("row_cursor_col", int'(cursor_col), 0);

    // 4: LF on the last row wraps to row 0
    for (int i = 0; i < 28; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i));
    wait_idle(cyc);
    chk_val("pre_lf_row", int'(cursor_row), 29);
    chk_val("pre_lf_col", int'(cursor_col), 5);
    wbase = wa.size();
    bbase = busy_tot;
    send_byte(8'h0A);
    wait_idle(cyc);
    chk_val("lf_write_count", wa.size() - wbase, 80);
    chk_val("lf_fill_errs", fill_errs(wbase, 0, 80), 0);
    hits = 0;
    for (int i = wbase; i < wa.size(); i++) if (wa[i] >= 12'd2320) hits++;
    chk_val("lf_row29_writes", hits, 0);
    chk_val("lf_busy_cycles", busy_tot - bbase, 80);
    chk_val("lf_cursor_row", int'(cursor_row), 0);
    chk_val("lf_cursor_col", int'(cursor_col), 0);

    // 5: backspace at col 3 and at col 0, ignored code, high-bit char
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h7A);
    wait_idle(cyc);
    wbase = wa.size();
    send_byte(8'h08);
    wait_idle(cyc);
    chk_val("bs_write_count", wa.size() - wbase, 1);
    chk_val("bs_addr", first_addr(wbase), 2);
    chk_val("bs_data", (wa.size() > wbase) ? int'(wd[wbase]) : -1, 8'h20);
    chk_val("bs_cursor_col", int'(cursor_col), 2);
    send_byte(8'h0D);
    wait_idle(cyc);
    wbase = wa.size();
    bbase = busy_tot;
    send_byte(8'h08);
    send_byte(8'h01);
    wait_idle(cyc);
    chk_val("bs0_write_count", wa.size() - wbase, 0);
    chk_val("bs0_cursor_col", int'(cursor_col), 0);
    chk_val("bs0_cursor_row", int'(cursor_row), 0);
    chk_val("bs0_busy_cycles", busy_tot - bbase, 0);
    wbase = wa.size();
    send_byte(8'h80);
    wait_idle(cyc);
    chk_val("hi_write_count", wa.size() - wbase, 1);
    chk_val("hi_data", (wa.size() > wbase) ? int'(wd[wbase]) : -1, 8'h80);
    chk_val("hi_cursor_col", int'(cursor_col), 1);

    // FF runs to completion and homes the cursor
    wbase = wa.size();
    bbase = busy_tot;
    send_byte(8'h0C);
    wait_idle(cyc);
    chk_val("ff_write_count", wa.size() - wbase, 2400);
    chk_val("ff_fill_errs", fill_errs(wbase, 0, 2400), 0);
    chk_val("ff_busy_cycles", busy_tot - bbase, 2400);
    chk_val("ff_cursor_col", int'(cursor_col), 0);
    chk_val("ff_cursor_row", int'(cursor_row), 0);

    // 6: reset in the middle of a screen clear
    send_byte(8'h51);
    send_byte(8'h0C);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(v_w_en === 1'b1 && address == 12'd1000) && cyc < 3000);
    chk_val("abort_reached_1000", int'(address), 1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("abort_v_w_en", int'(v_w_en), 0);
    chk_val("abort_ch_ready", int'(ch_ready), 0);
    chk_val("abort_busy", int'(busy), 1);
    chk_val("abort_cursor_col", int'(cursor_col), 0);
    repeat (3) @(negedge clk);
    wbase = wa.size();
    rst_n = 1'b1;
    wait_idle(cyc);
    chk_val("restart_first_addr", first_addr(wbase), 0);
    chk_val("restart_count", wa.size() - wbase, 2400);
    chk_val("restart_fill_errs", fill_errs(wbase, 0, 2400), 0);
    chk_val("restart_cycles", cyc, 2401);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
